xillybus_read_arbiter: RTL

XILLYBUS_READ_ARBITER -- requirements
Module: xillybus_read_arbiter

---
 rtl/xillybus_read_arbiter_pkg.sv | 36 +++
 rtl/xillybus_read_arbiter_buf.sv | 49 ++++
 rtl/xillybus_read_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xillybus_read_arbiter_pkg.sv
// Shared definitions for the Xillybus read arbiter: header word layout,
// header magic byte and the arbiter FSM state encoding.
package xillybus_read_arbiter_pkg;

    // Magic byte placed in the top of every burst header word.
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Bit offsets of the header fields inside the 32-bit header word.
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_RSVD_LSB  = 20;
    localparam int HDR_SEL_LSB   = 16;
    localparam int HDR_SEQ_LSB   = 8;
    localparam int HDR_CNT_LSB   = 0;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HDR     = 2'd2,
        ST_DRAIN   = 2'd3
    } arb_state_e;

    // Assemble a header word; the reserved nibble stays zero.
    function automatic logic [31:0] build_header(input logic [3:0] sel,
                                                 input logic [7:0] seq,
                                                 input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        w[HDR_SEL_LSB   +: 4] = sel;
        w[HDR_SEQ_LSB   +: 8] = seq;
        w[HDR_CNT_LSB   +: 8] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/xillybus_read_arbiter_buf.sv
// Burst buffer for the read arbiter: DEPTH x 32 storage with one write
// port and one registered read port. Occupancy is tracked by the caller.
module arb_burst_buf
    import xillybus_read_arbiter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    // Read register only changes on a read so the word holds between reads.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data register, cleared so the core sees zero after reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/xillybus_read_arbiter.sv
// Round-robin arbiter that collects bursts from NUM_SRC standard FIFOs and
// presents them to a Xillybus 32-bit read stream as a standard FIFO.
// Optional macro XILLY_ARB_HDR_EN prefixes every burst with a header word
// (magic, source, sequence number, word count).
module xillybus_read_arbiter
    import xillybus_read_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int BURST_MAX = 16
) (
    input  logic                  bus_clk,
    input  logic                  srst,
    input  logic [NUM_SRC-1:0]    src_empty,
    output logic [NUM_SRC-1:0]    src_rden,
    input  logic [32*NUM_SRC-1:0] src_data,
    input  logic                  user_r_read_32_rden,
    output logic                  user_r_read_32_empty,
    output logic [31:0]           user_r_read_32_data,
    output logic                  user_r_read_32_eof,
    input  logic                  user_r_read_32_open
);

    localparam int         SEL_W       = $clog2(NUM_SRC);
    localparam int         AW          = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [7:0] BURST_LIMIT = 8'(BURST_MAX);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       issued_q, issued_d;
    logic [7:0]       rd_ptr_q, rd_ptr_d;
    logic             pend_q, pend_d;
`ifdef XILLY_ARB_HDR_EN
    logic [7:0]       seq_q, seq_d;
    logic [31:0]      hdr_q, hdr_d;
    logic             out_sel_q, out_sel_d;
    logic [3:0]       sel_ext;
`endif

    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic             hi_found, lo_found;
    logic [SEL_W-1:0] hi_idx, lo_idx;
    logic             coll_rden;
    logic             out_active;
    logic             rd_fire;
    logic [31:0]      src_word;
    logic [7:0]       final_cnt;
    logic             buf_wr_en;
    logic             buf_rd_en;
    logic [31:0]      buf_rd_data;

    // Round-robin search: lowest non-empty index above last_grant wins,
    // otherwise wrap around to the lowest non-empty index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!src_empty[i]) begin
                if (SEL_W'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
        end
        grant_any = hi_found | lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Pick the data bus of the granted source.
    always_comb begin
        src_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                src_word = src_data[i*32 +: 32];
            end
        end
    end

    assign coll_rden = !srst && (state_q == ST_COLLECT) && !src_empty[sel_q]
                       && (issued_q < BURST_LIMIT);
    assign out_active = (state_q == ST_HDR) || (state_q == ST_DRAIN);
    assign rd_fire    = user_r_read_32_rden && out_active;

    // Only the granted source is ever read, and only while collecting.
    always_comb begin
        src_rden = '0;
        if (coll_rden) begin
            src_rden[sel_q] = 1'b1;
        end
    end

`ifdef XILLY_ARB_HDR_EN
    assign sel_ext = 4'(sel_q);
`endif

    // FSM next-state and datapath control. Words land in the buffer one
    // cycle after their source read; the first idle read cycle flushes the
    // last pending word and closes the burst.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        issued_d     = issued_q;
        rd_ptr_d     = rd_ptr_q;
        pend_d       = 1'b0;
        buf_wr_en    = 1'b0;
        buf_rd_en    = 1'b0;
        final_cnt    = cnt_q + {7'd0, pend_q};
`ifdef XILLY_ARB_HDR_EN
        seq_d        = seq_q;
        hdr_d        = hdr_q;
        out_sel_d    = out_sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (user_r_read_32_open && grant_any) begin
                    sel_d        = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    issued_d     = '0;
                    rd_ptr_d     = '0;
                    state_d      = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                buf_wr_en = pend_q;
                pend_d    = coll_rden;
                if (coll_rden) begin
                    issued_d = issued_q + 8'd1;
                end
                if (pend_q) begin
                    cnt_d = final_cnt;
                end
                if (!coll_rden) begin
`ifdef XILLY_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = (final_cnt == 8'd0) ? ST_IDLE : ST_DRAIN;
`endif
                end
            end
            ST_HDR: begin
`ifdef XILLY_ARB_HDR_EN
                if (rd_fire) begin
                    hdr_d     = build_header(sel_ext, seq_q, cnt_q);
                    out_sel_d = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DRAIN: begin
                if (rd_fire) begin
                    buf_rd_en = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 8'd1;
`ifdef XILLY_ARB_HDR_EN
                    out_sel_d = 1'b0;
`endif
                    if (rd_ptr_q == cnt_q - 8'd1) begin
                        state_d  = ST_IDLE;
                        rd_ptr_d = '0;
`ifdef XILLY_ARB_HDR_EN
                        seq_d    = seq_q + 8'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers; reset discards any burst in flight.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_grant_q <= SEL_W'(NUM_SRC - 1);
            cnt_q        <= '0;
            issued_q     <= '0;
            rd_ptr_q     <= '0;
            pend_q       <= 1'b0;
`ifdef XILLY_ARB_HDR_EN
            seq_q        <= '0;
            hdr_q        <= '0;
            out_sel_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_q       <= pend_d;
`ifdef XILLY_ARB_HDR_EN
            seq_q        <= seq_d;
            hdr_q        <= hdr_d;
            out_sel_q    <= out_sel_d;
`endif
        end
    end

    arb_burst_buf #(
        .DEPTH (BURST_MAX),
        .AW    (AW)
    ) u_buf (
        .clk     (bus_clk),
        .srst    (srst),
        .wr_en   (buf_wr_en),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_data (src_word),
        .rd_en   (buf_rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (buf_rd_data)
    );

    assign user_r_read_32_empty = srst || !out_active;
    assign user_r_read_32_eof   = 1'b0;
`ifdef XILLY_ARB_HDR_EN
    assign user_r_read_32_data  = out_sel_q ? hdr_q : buf_rd_data;
`else
    assign user_r_read_32_data  = buf_rd_data;
`endif

endmodule
